// File: rtl/tone_pkg.sv
// Shared types and constants for the tone detector: FSM states and the
// C3..C4 half-period table (cycles of a 50 MHz clock per half wave).
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } tone_state_t;

  localparam int NUM_NOTES = 8;

  // 50e6 / f / 2, truncated; index 0 = C3 .. 7 = C4
  localparam int NOTE_HALF_PERIOD [0:NUM_NOTES-1] = '{
    191117, 170265, 151690, 143176, 127551, 113636, 101239, 95555
  };

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone input followed by a
// one-stage delay; the edge pulse flags any transition (rising or falling).
module tone_edge_sync
  import tone_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Metastability filter plus one delayed copy for transition detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= tone_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign edge_pulse = sync2 ^ sync2_d;

endmodule

// File: rtl/tone_detector.sv
// Measures the half-period of an incoming square wave, matches it against
// the C3..C4 note table and reports a note once several consecutive
// half-periods agree. TABLE_SHIFT scales the table down (0 = real pitches).
module tone_detector
  import tone_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int TOL_SHIFT   = 6,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TABLE_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [2:0]       note_idx,
  output logic             note_valid,
  output logic             note_start,
  output logic             note_end,
  output logic [CNT_W-1:0] half_period
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [MC_W-1:0]  LOCK_VAL    = MC_W'(LOCK_COUNT);

  if (TIMEOUT_CYC >= (1 << CNT_W)) begin : g_timeout_too_wide
    $error("TIMEOUT_CYC does not fit in CNT_W bits");
  end

  logic              edge_pulse;
  logic [CNT_W-1:0]  hp_cnt;
  logic              timeout_ev;
  logic              match_hit;
  logic [2:0]        match_idx;
  logic [CNT_W:0]    meas;
  logic [CNT_W:0]    ref_hp;
  logic [CNT_W:0]    diff;

  tone_state_t       state, state_next;
  logic [2:0]        cand, cand_next;
  logic [MC_W-1:0]   match_cnt, mc_next;
  logic [2:0]        idx_next;
  logic              valid_next, start_next, end_next;
  logic [2:0]        seed_cand;
  logic [MC_W-1:0]   seed_mc;
  logic              seed_lock;

  tone_edge_sync u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .edge_pulse (edge_pulse)
  );

  // Half-period counter: restarts at 1 on every edge, saturates at the timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_cnt      <= TIMEOUT_VAL;
      half_period <= '0;
    end else if (edge_pulse) begin
      half_period <= hp_cnt;
      hp_cnt      <= CNT_W'(1);
    end else if (hp_cnt != TIMEOUT_VAL) begin
      hp_cnt      <= hp_cnt + CNT_W'(1);
    end else begin
      hp_cnt      <= hp_cnt;
    end
  end

  // Silence is reported once, in the cycle before the counter saturates
  assign timeout_ev = !edge_pulse && (hp_cnt == (TIMEOUT_VAL - CNT_W'(1)));

  // Table match on the running count; scanning downward leaves the lowest hit
  always_comb begin
    match_hit = 1'b0;
    match_idx = 3'd0;
    meas      = {1'b0, hp_cnt};
    ref_hp    = '0;
    diff      = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      ref_hp = (CNT_W+1)'(NOTE_HALF_PERIOD[i] >> TABLE_SHIFT);
      if (meas >= ref_hp) begin
        diff = meas - ref_hp;
      end else begin
        diff = ref_hp - meas;
      end
      if (diff <= (ref_hp >> TOL_SHIFT)) begin
        match_hit = 1'b1;
        match_idx = 3'(i);
      end else begin
        match_hit = match_hit;
      end
    end
  end

  // Candidate tracking shared by ACQUIRE and the fall-out path of LOCKED
  always_comb begin
    seed_cand = cand;
    seed_mc   = '0;
    seed_lock = 1'b0;
    if (match_hit) begin
      if ((match_idx == cand) && (match_cnt != '0)) begin
        seed_mc   = match_cnt + MC_W'(1);
        seed_lock = (seed_mc == LOCK_VAL);
      end else begin
        seed_cand = match_idx;
        seed_mc   = MC_W'(1);
      end
    end else begin
      seed_mc = '0;
    end
  end

  // Next-state and output decode for the acquisition FSM
  always_comb begin
    state_next = state;
    cand_next  = cand;
    mc_next    = match_cnt;
    idx_next   = note_idx;
    valid_next = note_valid;
    start_next = 1'b0;
    end_next   = 1'b0;
    case (state)
      IDLE: begin
        if (edge_pulse) begin
          state_next = ACQUIRE;
          mc_next    = '0;
        end else begin
          state_next = IDLE;
        end
      end
      ACQUIRE: begin
        if (edge_pulse) begin
          cand_next = seed_cand;
          mc_next   = seed_mc;
          if (seed_lock) begin
            state_next = LOCKED;
            idx_next   = cand;
            valid_next = 1'b1;
            start_next = 1'b1;
          end else begin
            state_next = ACQUIRE;
          end
        end else if (timeout_ev) begin
          state_next = IDLE;
          mc_next    = '0;
        end else begin
          state_next = ACQUIRE;
        end
      end
      LOCKED: begin
        if (edge_pulse) begin
          if (match_hit && (match_idx == note_idx)) begin
            state_next = LOCKED;
          end else begin
            state_next = ACQUIRE;
            valid_next = 1'b0;
            end_next   = 1'b1;
            cand_next  = seed_cand;
            mc_next    = seed_mc;
          end
        end else if (timeout_ev) begin
          state_next = IDLE;
          valid_next = 1'b0;
          end_next   = 1'b1;
          mc_next    = '0;
        end else begin
          state_next = LOCKED;
        end
      end
      default: begin
        state_next = IDLE;
        mc_next    = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cand       <= 3'd0;
      match_cnt  <= '0;
      note_idx   <= 3'd0;
      note_valid <= 1'b0;
      note_start <= 1'b0;
      note_end   <= 1'b0;
    end else begin
      state      <= state_next;
      cand       <= cand_next;
      match_cnt  <= mc_next;
      note_idx   <= idx_next;
      note_valid <= valid_next;
      note_start <= start_next;
      note_end   <= end_next;
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector with the note table scaled down by 2^7 and a short
// silence timeout so every scenario fits in a modest number of cycles.
module tb_tone_detector;

  localparam int CNT_W  = 20;
  localparam int TO     = 3000;
  localparam int SH     = 7;
  localparam int LOCKN  = 4;
  localparam int HP_D3  = 1330;  // 170265 >> 7
  localparam int HP_E3  = 1185;  // 151690 >> 7
  localparam int HP_C4  = 746;   // 95555  >> 7

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tone_in = 1'b0;
  logic [2:0]       note_idx;
  logic             note_valid;
  logic             note_start;
  logic             note_end;
  logic [CNT_W-1:0] half_period;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int end_cnt = 0;
  int start_cyc = -1;
  int end_cyc = -1;

  int note_tbl [0:7] = '{191117, 170265, 151690, 143176, 127551, 113636, 101239, 95555};

  // behavioural model state
  int tin_hist [0:3];
  int since_edge;
  int mstate;   // 0 silent, 1 searching, 2 locked
  int mcand, mcnt, mnote, mvalid, mstart, mend, mhalf;

  always #5 clk = ~clk;

  tone_detector #(
    .CNT_W       (CNT_W),
    .TOL_SHIFT   (6),
    .LOCK_COUNT  (LOCKN),
    .TIMEOUT_CYC (TO),
    .TABLE_SHIFT (SH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .note_idx    (note_idx),
    .note_valid  (note_valid),
    .note_start  (note_start),
    .note_end    (note_end),
    .half_period (half_period)
  );

  // which note (lowest index) a measured half-period belongs to, or -1
  function automatic int classify(input int m);
    int t;
    int d;
    for (int i = 0; i < 8; i++) begin
      t = note_tbl[i] >> SH;
      d = (m > t) ? m - t : t - m;
      if (d <= (t >> 6)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) tin_hist[i] = 0;
    since_edge = TO;
    mstate = 0; mcand = 0; mcnt = 0; mnote = 0;
    mvalid = 0; mstart = 0; mend = 0; mhalf = 0;
  endtask

  // track a candidate note across consecutive half-periods
  task automatic model_track(input int k);
    if (k < 0) begin
      mcnt = 0;
    end else if (k == mcand && mcnt > 0) begin
      mcnt = mcnt + 1;
      if (mcnt == LOCKN) begin
        mstate = 2; mnote = k; mvalid = 1; mstart = 1;
      end
    end else begin
      mcand = k; mcnt = 1;
    end
  endtask

  // one clock of the model, given the tone level seen at this clock edge
  task automatic model_step(input int tin);
    bit edge_seen;
    bit quiet;
    int k;
    for (int i = 3; i > 0; i--) tin_hist[i] = tin_hist[i-1];
    tin_hist[0] = tin;
    // a transition becomes visible to the measurement three clocks later
    edge_seen = (tin_hist[2] != tin_hist[3]);
    quiet = !edge_seen && (since_edge == TO - 1);
    mstart = 0;
    mend = 0;
    if (edge_seen) begin
      mhalf = since_edge;
      k = classify(since_edge);
      since_edge = 1;
      if (mstate == 0) begin
        mstate = 1; mcnt = 0;
      end else if (mstate == 1) begin
        model_track(k);
      end else if (k != mnote) begin
        mstate = 1; mvalid = 0; mend = 1;
        model_track(k);
      end
    end else begin
      if (quiet && mstate == 1) begin
        mstate = 0; mcnt = 0;
      end else if (quiet && mstate == 2) begin
        mstate = 0; mvalid = 0; mend = 1; mcnt = 0;
      end
      if (since_edge < TO) since_edge = since_edge + 1;
    end
  endtask

  // model update at each clock edge, then a full output comparison
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst) model_reset();
      else model_step(int'(tone_in));
      #1;
      checks = checks + 1;
      if (int'(note_idx) != mnote || int'(note_valid) != mvalid || int'(note_start) != mstart ||
          int'(note_end) != mend || int'(half_period) != mhalf) begin
        errors = errors + 1;
        $display("FAIL model_compare cycle %0d: got idx=%0d valid=%0d start=%0d end=%0d hp=%0d, expected idx=%0d valid=%0d start=%0d end=%0d hp=%0d",
                 cyc, note_idx, note_valid, note_start, note_end, half_period,
                 mnote, mvalid, mstart, mend, mhalf);
      end
      if (note_start) begin start_cnt = start_cnt + 1; start_cyc = cyc; end
      if (note_end)   begin end_cnt = end_cnt + 1;     end_cyc = cyc;   end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // toggle tone_in, then hold it for the rest of an h-cycle half-period
  task automatic flip_wait(input int h, output int at);
    @(negedge clk);
    tone_in = ~tone_in;
    at = cyc;
    repeat (h - 1) @(negedge clk);
  endtask

  task automatic silence();
    repeat (TO + 10) @(negedge clk);
  endtask

  int at;
  int s0;
  int e0;

  initial begin
    // reset held while the input toggles
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tone_in = ~tone_in;
    end
    check("reset_valid", int'(note_valid), 0);
    check("reset_idx", int'(note_idx), 0);
    check("reset_pulses", int'({note_start, note_end}), 0);
    check("reset_half_period", int'(half_period), 0);
    tone_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_release", int'(note_valid), 0);

    // D3 lock: first edge discarded, four matches lock
    repeat (4) flip_wait(HP_D3, at);
    check("d3_not_early", int'(note_valid), 0);
    flip_wait(HP_D3, at);
    check("d3_start_latency", start_cyc - at, 3);
    check("d3_valid", int'(note_valid), 1);
    check("d3_idx", int'(note_idx), 1);
    check("d3_half_period", int'(half_period), HP_D3);
    check("d3_start_count", start_cnt, 1);

    // change to E3 without a gap
    flip_wait(HP_E3, at);
    check("e3_first_edge_still_d3", int'(note_valid), 1);
    flip_wait(HP_E3, at);
    check("e3_end_latency", end_cyc - at, 3);
    check("e3_dropped", int'(note_valid), 0);
    check("e3_end_count", end_cnt, 1);
    repeat (3) flip_wait(HP_E3, at);
    check("e3_valid", int'(note_valid), 1);
    check("e3_idx", int'(note_idx), 2);
    check("e3_half_period", int'(half_period), HP_E3);
    check("e3_start_count", start_cnt, 2);

    // silence ends the note
    silence();
    check("silence_valid", int'(note_valid), 0);
    check("silence_end_count", end_cnt, 2);
    check("silence_end_latency", end_cyc - at, TO + 2);

    // next tone needs five edges again
    repeat (4) flip_wait(HP_D3, at);
    check("relock_not_early", int'(note_valid), 0);
    flip_wait(HP_D3, at);
    check("relock_valid", int'(note_valid), 1);
    check("relock_start_count", start_cnt, 3);
    silence();

    // tolerance boundary: 1330 + (1330 >> 6) = 1350 matches
    repeat (5) flip_wait(HP_D3 + 20, at);
    check("tol_in_valid", int'(note_valid), 1);
    check("tol_in_idx", int'(note_idx), 1);
    check("tol_in_half_period", int'(half_period), 1350);
    silence();

    // one cycle further out never locks
    s0 = start_cnt;
    repeat (8) flip_wait(HP_D3 + 21, at);
    check("tol_out_valid", int'(note_valid), 0);
    check("tol_out_no_start", start_cnt, s0);
    check("tol_out_half_period", int'(half_period), 1351);
    silence();

    // C4 lock, then reset while locked
    repeat (5) flip_wait(HP_C4, at);
    check("c4_valid", int'(note_valid), 1);
    check("c4_idx", int'(note_idx), 7);
    e0 = end_cnt;
    s0 = start_cnt;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midlock_reset_valid", int'(note_valid), 0);
    check("midlock_reset_idx", int'(note_idx), 0);
    tone_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midlock_no_end", end_cnt, e0);
    repeat (5) flip_wait(HP_C4, at);
    check("after_reset_valid", int'(note_valid), 1);
    check("after_reset_idx", int'(note_idx), 7);
    check("after_reset_start_count", start_cnt, s0 + 1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
